multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001: Port clk, input, 1, single clock; all state updates on the rising edge.
- REQ-002: Port reset, input, 1, synchronous, active-high; sampled on the rising clk edge.
- REQ-003: Port Opcode, input, 7, instruction opcode field, valid from DECODE onward.
- REQ-004: Port Funct, input, 4, {funct7[5], funct3}.
- REQ-005: Port Zero, input, 1, ALU zero flag.
- REQ-006: Port mem_ready, input, 1, memory handshake; the access completes in any cycle where it is high during a memory state.
- REQ-007: Ports InstrRead, MemRead, MemWrite, output, 1 each, memory request strobes.
- REQ-008: Ports PCWrite, IRWrite, RegWrite, MemtoReg, ALUSrc, Branch, output, 1 each, datapath enables.
- REQ-009: Port Operation, output, 4, ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or.
- REQ-010: Port Illegal, output, 1, sticky illegal-opcode flag.
- REQ-011: Port retired, output, 16, count of completed instructions.
- REQ-012: Port state, output, 4, current state encoding, for debug.

Function
- REQ-013: States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_MEM=8, BRANCH=9, ILLEGAL=10.
- REQ-014: FETCH drives InstrRead=1 and holds while mem_ready=0. On mem_ready=1, IRWrite=1, PCWrite=1 for that single cycle, then go to DECODE.
- REQ-015: DECODE dispatches on Opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other value -> ILLEGAL
- REQ-016: EXEC_R: ALUSrc=0; Operation from Funct (0000 add, 1000 sub, 0111 and, 0110 or; any other Funct -> add). Next state WB_R.
- REQ-017: EXEC_I: ALUSrc=1; Operation from Funct[2:0] (111 and, 110 or, all others add). Next state WB_R.
- REQ-018: WB_R: RegWrite=1 for one cycle, keeping the same ALUSrc/Operation as the preceding EXEC state. Next state FETCH.
- REQ-019: MEM_ADDR: ALUSrc=1, Operation=add. Next state MEM_RD for a load, MEM_WR for a store.
- REQ-020: MEM_RD drives MemRead=1 and holds while mem_ready=0; on mem_ready=1 go to WB_MEM. MEM_WR behaves the same with MemWrite=1 and goes to FETCH.
- REQ-021: WB_MEM: RegWrite=1, MemtoReg=1 for one cycle. Next state FETCH.
- REQ-022: BRANCH: ALUSrc=0, Operation=sub, Branch=1; PCWrite=Zero in that same cycle. Next state FETCH.
- REQ-023: ILLEGAL: Illegal=1, all strobes and enables 0; the state holds until reset.
- REQ-024: Any output not named for a state is 0 in that state; Operation defaults to 0010.
- REQ-025: Zero-wait latencies, FETCH to FETCH: R/I-type 4 cycles, load 5, store 4, branch 3. Each cycle of mem_ready=0 adds one cycle.
- REQ-026: retired increments by 1 on the cycle leaving WB_R, WB_MEM, MEM_WR (with mem_ready=1) or BRANCH. It wraps from 0xFFFF to 0x0000 and never increments for an illegal opcode.
- REQ-027: InstrRead, MemRead and MemWrite are mutually exclusive in every cycle.

Reset
- REQ-028: When reset=1 at an edge: state=FETCH, retired=0, Illegal=0. This holds from any state, including mid-wait in MEM_RD, MEM_WR or ILLEGAL, and reset wins over mem_ready.
- REQ-029: While reset is asserted, all strobes and enables are 0 and Operation=0010. The first FETCH request occurs in the cycle after reset deasserts.

Verification
- REQ-030: R-type sub (Opcode 0110011, Funct 1000), mem_ready tied 1 -> states 0,1,2,7,0; Operation=0110 in EXEC_R and WB_R; RegWrite high exactly one cycle; retired 0->1.
- REQ-031: Load with mem_ready low for 3 cycles in MEM_RD -> MemRead held 4 cycles; 8 cycles FETCH to FETCH; MemtoReg=RegWrite=1 in WB_MEM only.
- REQ-032: Branch with Zero=1, then Zero=0 -> PCWrite pulses in BRANCH only for the Zero=1 case; Branch=1 and Operation=0110 in both cases; each takes 3 cycles.
- REQ-033: Opcode 1111111 -> ILLEGAL, Illegal=1 and held for 20 cycles; retired unchanged; reset returns to FETCH with Illegal=0.
- REQ-034: Reset asserted during a MEM_WR wait -> MemWrite=0 the next cycle, state=0, retired=0.
- REQ-035: Preload 65535 retired instructions (or force the counter), then complete one store -> retired=0x0000.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
//
// Control unit for a multicycle RV32-subset datapath. One instruction at a
// time walks through FETCH -> DECODE -> execute/memory/writeback states, and
// the unit drives the memory strobes, the datapath enables and the ALU
// operation for whichever state it is in. Memory states wait on mem_ready.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   Opcode     : instruction opcode field, valid from DECODE onward
//   Funct      : {funct7[5], funct3}
//   Zero       : ALU zero flag, used in BRANCH
//   mem_ready  : memory handshake, completes an access in the cycle it is high
//   InstrRead  : instruction fetch request
//   MemRead    : data load request
//   MemWrite   : data store request
//   PCWrite    : PC update enable
//   IRWrite    : instruction register load enable
//   RegWrite   : register file write enable
//   MemtoReg   : selects memory data for register writeback
//   ALUSrc     : selects the immediate as ALU operand B
//   Branch     : branch compare in progress
//   Operation  : ALU op (0010 add, 0110 sub, 0000 and, 0001 or)
//   Illegal    : sticky illegal-opcode flag, cleared only by reset
//   retired    : number of completed instructions, wraps at 16 bits
//   state      : current state encoding, for debug
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic [3:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        InstrRead,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        Branch,
    output logic [3:0]  Operation,
    output logic        Illegal,
    output logic [15:0] retired,
    output logic [3:0]  state
);

    // Opcodes recognised by DECODE
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU operation codes
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        ILLEGAL  = 4'd10
    } state_t;

    state_t      current_state;
    logic [3:0]  exec_op;
    logic        exec_src;
    logic        is_store;
    logic        illegal_flag;
    logic [15:0] retired_count;

    // R-type ALU op from {funct7[5], funct3}; unknown combinations add.
    function automatic logic [3:0] r_type_op(input logic [3:0] f);
        case (f)
            4'b1000: r_type_op = OP_SUB;
            4'b0111: r_type_op = OP_AND;
            4'b0110: r_type_op = OP_OR;
            default: r_type_op = OP_ADD;
        endcase
    endfunction

    // I-type ALU op from funct3 only; funct7[5] carries immediate bits here.
    function automatic logic [3:0] i_type_op(input logic [2:0] f3);
        case (f3)
            3'b111:  i_type_op = OP_AND;
            3'b110:  i_type_op = OP_OR;
            default: i_type_op = OP_ADD;
        endcase
    endfunction

    // State register plus the small amount of context that must survive
    // across states: the EXEC ALU setup is replayed during WB_R, and the
    // load/store choice is captured at DECODE so MEM_ADDR does not depend
    // on Opcode still being held. The retire counter advances on every
    // transition that completes an instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= FETCH;
            retired_count <= 16'd0;
            illegal_flag  <= 1'b0;
            exec_op       <= OP_ADD;
            exec_src      <= 1'b0;
            is_store      <= 1'b0;
        end else begin
            case (current_state)
                FETCH: begin
                    if (mem_ready) begin
                        current_state <= DECODE;
                    end
                end
                DECODE: begin
                    case (Opcode)
                        OPC_RTYPE:  current_state <= EXEC_R;
                        OPC_ITYPE:  current_state <= EXEC_I;
                        OPC_LOAD: begin
                            is_store      <= 1'b0;
                            current_state <= MEM_ADDR;
                        end
                        OPC_STORE: begin
                            is_store      <= 1'b1;
                            current_state <= MEM_ADDR;
                        end
                        OPC_BRANCH: current_state <= BRANCH;
                        default: begin
                            illegal_flag  <= 1'b1;
                            current_state <= ILLEGAL;
                        end
                    endcase
                end
                EXEC_R: begin
                    exec_op       <= r_type_op(Funct);
                    exec_src      <= 1'b0;
                    current_state <= WB_R;
                end
                EXEC_I: begin
                    exec_op       <= i_type_op(Funct[2:0]);
                    exec_src      <= 1'b1;
                    current_state <= WB_R;
                end
                WB_R: begin
                    retired_count <= retired_count + 16'd1;
                    current_state <= FETCH;
                end
                MEM_ADDR: begin
                    current_state <= is_store ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    if (mem_ready) begin
                        current_state <= WB_MEM;
                    end
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        retired_count <= retired_count + 16'd1;
                        current_state <= FETCH;
                    end
                end
                WB_MEM: begin
                    retired_count <= retired_count + 16'd1;
                    current_state <= FETCH;
                end
                BRANCH: begin
                    retired_count <= retired_count + 16'd1;
                    current_state <= FETCH;
                end
                ILLEGAL: begin
                    current_state <= ILLEGAL;
                end
                default: begin
                    current_state <= FETCH;
                end
            endcase
        end
    end

    // Output decode. IRWrite/PCWrite in FETCH and PCWrite in BRANCH must
    // react to mem_ready and Zero in the same cycle, so this is decoded from
    // the registered state plus those inputs. Holding reset forces every
    // strobe and enable low even though the state register already reads
    // FETCH, so the first fetch request appears once reset is released.
    always_comb begin
        InstrRead = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrc    = 1'b0;
        Branch    = 1'b0;
        Operation = OP_ADD;
        if (!reset) begin
            case (current_state)
                FETCH: begin
                    InstrRead = 1'b1;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                EXEC_R: begin
                    ALUSrc    = 1'b0;
                    Operation = r_type_op(Funct);
                end
                EXEC_I: begin
                    ALUSrc    = 1'b1;
                    Operation = i_type_op(Funct[2:0]);
                end
                WB_R: begin
                    RegWrite  = 1'b1;
                    ALUSrc    = exec_src;
                    Operation = exec_op;
                end
                MEM_ADDR: begin
                    ALUSrc    = 1'b1;
                    Operation = OP_ADD;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                end
                WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                BRANCH: begin
                    ALUSrc    = 1'b0;
                    Operation = OP_SUB;
                    Branch    = 1'b1;
                    PCWrite   = Zero;
                end
                default: begin
                end
            endcase
        end
    end

    assign Illegal = illegal_flag;
    assign retired = retired_count;
    assign state   = current_state;

endmodule

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
//
// Randomised instruction stream against multicycle_control. Each issued
// instruction pushes its expected per-instruction profile (cycle count,
// strobe counts, ALU setup at writeback, retire count) onto a queue; a
// monitor accumulates what the DUT actually does between retirements and
// pops/compares on every retire. A memory responder supplies mem_ready with
// per-instruction wait counts. Directed sections cover the illegal opcode,
// reset mid-store-wait and retire counter wrap.
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic        Zero;
    logic        mem_ready;
    logic        InstrRead, MemRead, MemWrite;
    logic        PCWrite, IRWrite, RegWrite, MemtoReg, ALUSrc, Branch;
    logic [3:0]  Operation;
    logic        Illegal;
    logic [15:0] retired;
    logic [3:0]  state;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .InstrRead(InstrRead), .MemRead(MemRead),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .Branch(Branch), .Operation(Operation), .Illegal(Illegal),
        .retired(retired), .state(state)
    );

    always #10 clk = ~clk;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_ILL = 5;

    localparam int ALU_ADD = 2;
    localparam int ALU_SUB = 6;
    localparam int ALU_AND = 0;
    localparam int ALU_OR  = 1;

    typedef struct {
        int          n_cycles;
        int          n_instr;
        int          n_memrd;
        int          n_memwr;
        int          n_regwr;
        int          n_m2r;
        int          n_pcw;
        int          n_irw;
        int          n_br;
        int          ev_op;
        int          ev_src;
        logic [15:0] ret;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          fetch_wait = 0;
    int          mem_wait   = 0;
    int          resp_cnt   = 0;
    exp_t        sb[$];
    bit          mon_active = 1'b0;
    bit          mon_prev   = 1'b0;
    logic [15:0] model_retired = 16'd0;
    logic [15:0] last_ret;
    int acc_cycles, acc_ir, acc_mr, acc_mw, acc_rw, acc_m2r, acc_pcw, acc_irw, acc_br;
    int acc_op, acc_src;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference profile of one instruction, FETCH to next FETCH, taken
    // straight from the instruction-class rules and wait counts.
    function automatic exp_t model(input int kind, input logic [3:0] f,
                                   input logic z, input int fw, input int mw);
        exp_t e;
        e = '{default: 0};
        e.n_instr = fw + 1;
        e.n_irw   = 1;
        e.n_pcw   = 1;
        e.ev_op   = ALU_ADD;
        e.ev_src  = 0;
        case (kind)
            K_R: begin
                e.n_cycles = fw + 4;
                e.n_regwr  = 1;
                if (f == 4'b1000)      e.ev_op = ALU_SUB;
                else if (f == 4'b0111) e.ev_op = ALU_AND;
                else if (f == 4'b0110) e.ev_op = ALU_OR;
            end
            K_I: begin
                e.n_cycles = fw + 4;
                e.n_regwr  = 1;
                e.ev_src   = 1;
                if (f[2:0] == 3'b111)      e.ev_op = ALU_AND;
                else if (f[2:0] == 3'b110) e.ev_op = ALU_OR;
            end
            K_LD: begin
                e.n_cycles = fw + mw + 5;
                e.n_memrd  = mw + 1;
                e.n_regwr  = 1;
                e.n_m2r    = 1;
            end
            K_ST: begin
                e.n_cycles = fw + mw + 4;
                e.n_memwr  = mw + 1;
            end
            default: begin
                e.n_cycles = fw + 3;
                e.n_br     = 1;
                e.ev_op    = ALU_SUB;
                e.n_pcw    = 1 + int'(z);
            end
        endcase
        return e;
    endfunction

    task automatic issue(input int kind, input logic [3:0] f, input logic z,
                         input int fw, input int mw, input bit push);
        exp_t e;
        Opcode     = opcode_of(kind);
        Funct      = f;
        Zero       = z;
        fetch_wait = fw;
        mem_wait   = mw;
        if (push) begin
            model_retired = model_retired + 16'd1;
            e     = model(kind, f, z, fw, mw);
            e.ret = model_retired;
            sb.push_back(e);
        end
    endtask

    // Waits for the first cycle of a fresh fetch (InstrRead low, then high).
    task automatic sync_fetch(output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (InstrRead && n < 300) begin tick(); n++; end
        while (!InstrRead && n < 300) begin tick(); n++; end
        if (n >= 300) begin
            ok = 1'b0;
            checks++;
            failures++;
            $display("[TB] FAIL fetch_sync: no new fetch within 300 cycles, state=%0d", state);
        end
    endtask

    task automatic apply_stimulus(input int kind, input logic [3:0] f, input logic z,
                                  input int fw, input int mw, input bit push);
        bit ok;
        sync_fetch(ok);
        issue(kind, f, z, fw, mw, push);
    endtask

    // Memory responder: holds mem_ready low for the requested number of
    // cycles of each access, then grants it.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (InstrRead || MemRead || MemWrite) begin
                if (resp_cnt < (InstrRead ? fetch_wait : mem_wait)) begin
                    mem_ready = 1'b0;
                    resp_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    resp_cnt  = 0;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                resp_cnt  = 0;
            end
        end
    end

    task automatic clear_acc;
        acc_cycles = 0; acc_ir = 0; acc_mr = 0; acc_mw = 0; acc_rw = 0;
        acc_m2r = 0; acc_pcw = 0; acc_irw = 0; acc_br = 0;
        acc_op = ALU_ADD; acc_src = 0;
    endtask

    // Monitor: a change of retired closes the current instruction profile.
    always begin
        exp_t e;
        @(negedge clk);
        #6;
        if (mon_active) begin
            if (!mon_prev) begin
                clear_acc();
            end else if (retired != last_ret) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_retire: retired=%0d with empty scoreboard", retired);
                end else begin
                    e = sb.pop_front();
                    check_output("cycles",    acc_cycles, e.n_cycles);
                    check_output("instrread", acc_ir,     e.n_instr);
                    check_output("memread",   acc_mr,     e.n_memrd);
                    check_output("memwrite",  acc_mw,     e.n_memwr);
                    check_output("regwrite",  acc_rw,     e.n_regwr);
                    check_output("memtoreg",  acc_m2r,    e.n_m2r);
                    check_output("pcwrite",   acc_pcw,    e.n_pcw);
                    check_output("irwrite",   acc_irw,    e.n_irw);
                    check_output("branch",    acc_br,     e.n_br);
                    check_output("wb_op",     acc_op,     e.ev_op);
                    check_output("wb_alusrc", acc_src,    e.ev_src);
                    check_output("retired",   int'(retired), int'(e.ret));
                end
                clear_acc();
            end
            last_ret = retired;
            acc_cycles++;
            acc_ir  += int'(InstrRead);
            acc_mr  += int'(MemRead);
            acc_mw  += int'(MemWrite);
            acc_rw  += int'(RegWrite);
            acc_m2r += int'(MemtoReg);
            acc_pcw += int'(PCWrite);
            acc_irw += int'(IRWrite);
            acc_br  += int'(Branch);
            if (RegWrite || Branch) begin
                acc_op  = int'(Operation);
                acc_src = int'(ALUSrc);
            end
            check_output("strobe_exclusive",
                         int'((int'(InstrRead) + int'(MemRead) + int'(MemWrite)) <= 1), 1);
        end
        mon_prev = mon_active;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          kind, sel, fw, mw, n;
        logic [3:0]  f;
        logic [15:0] r0;
        bit          ok;
        int          exp_states[5];
        int          rw_seen;

        exp_states = '{0, 1, 2, 7, 0};
        reset  = 1'b1;
        Opcode = 7'd0;
        Funct  = 4'd0;
        Zero   = 1'b0;
        repeat (3) tick();

        // Reset state with every strobe held low
        check_output("reset_state",   int'(state), 0);
        check_output("reset_retired", int'(retired), 0);
        check_output("reset_illegal", int'(Illegal), 0);
        check_output("reset_strobes", int'({InstrRead, MemRead, MemWrite, PCWrite, IRWrite,
                                            RegWrite, MemtoReg, ALUSrc, Branch}), 0);
        check_output("reset_operation", int'(Operation), ALU_ADD);

        // First instruction is set up before release: R-type sub, no waits
        issue(K_R, 4'b1000, 1'b0, 0, 0, 1'b1);
        reset = 1'b0;
        #1;
        check_output("first_fetch", int'(InstrRead), 1);
        mon_active = 1'b1;

        // Directed openers: load with 3 wait cycles, branch taken / not taken
        apply_stimulus(K_LD, 4'b0000, 1'b0, 0, 3, 1'b1);
        apply_stimulus(K_BR, 4'b0000, 1'b1, 0, 0, 1'b1);
        apply_stimulus(K_BR, 4'b0000, 1'b0, 0, 0, 1'b1);
        apply_stimulus(K_I,  4'b1111, 1'b0, 0, 0, 1'b1);
        apply_stimulus(K_ST, 4'b0000, 1'b0, 2, 1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            f    = 4'($urandom_range(0, 15));
            if (kind == K_R) begin
                sel = $urandom_range(0, 4);
                if (sel == 0)      f = 4'b0000;
                else if (sel == 1) f = 4'b1000;
                else if (sel == 2) f = 4'b0111;
                else if (sel == 3) f = 4'b0110;
            end
            fw = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            mw = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            apply_stimulus(kind, f, 1'($urandom_range(0, 1)), fw, mw, 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 300) begin tick(); n++; end
        check_output("scoreboard_drained", sb.size(), 0);
        mon_active = 1'b0;

        // R-type sub state trace
        apply_stimulus(K_R, 4'b1000, 1'b0, 0, 0, 1'b0);
        r0      = retired;
        rw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("rtype_state%0d", i), int'(state), exp_states[i]);
            if (i == 2 || i == 3) check_output("rtype_op", int'(Operation), ALU_SUB);
            rw_seen += int'(RegWrite);
            if (i < 4) tick();
        end
        check_output("rtype_regwrite_cycles", rw_seen, 1);
        check_output("rtype_retired", int'(retired), int'(r0 + 16'd1));

        // Illegal opcode: state and flag stick, nothing retires
        apply_stimulus(K_ILL, 4'b0000, 1'b0, 0, 0, 1'b0);
        r0 = retired;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            check_output("illegal_flag",  int'(Illegal), 1);
            check_output("illegal_state", int'(state), 10);
            check_output("illegal_strobes", int'({InstrRead, MemRead, MemWrite, PCWrite, IRWrite,
                                                  RegWrite, MemtoReg, ALUSrc, Branch}), 0);
            tick();
        end
        check_output("illegal_retired", int'(retired), int'(r0));
        reset = 1'b1;
        tick();
        check_output("illegal_reset_state",   int'(state), 0);
        check_output("illegal_reset_flag",    int'(Illegal), 0);
        check_output("illegal_reset_retired", int'(retired), 0);

        // Reset while a store is waiting on memory
        issue(K_ST, 4'b0000, 1'b0, 0, 30, 1'b0);
        reset = 1'b0;
        n = 0;
        while (!MemWrite && n < 50) begin tick(); n++; end
        tick();
        tick();
        check_output("memwr_wait_strobe", int'(MemWrite), 1);
        check_output("memwr_wait_state",  int'(state), 6);
        reset = 1'b1;
        tick();
        check_output("memwr_reset_strobe",  int'(MemWrite), 0);
        check_output("memwr_reset_state",   int'(state), 0);
        check_output("memwr_reset_retired", int'(retired), 0);

        // Retire counter wrap on a completed store
        issue(K_ST, 4'b0000, 1'b0, 0, 0, 1'b0);
        reset = 1'b0;
        force dut.retired_count = 16'hFFFF;
        tick();
        release dut.retired_count;
        sync_fetch(ok);
        check_output("retired_wrap", int'(retired), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
